kettle_sensor_frontend: RTL and testbench
=========================================

# kettle_sensor_frontend

Conditioning stage directly upstream of the kettle controller FSM. Synchronises and debounces the raw start push-button, averages the 8-bit temperature ADC stream, applies hysteresis to the water-level ADC stream, and watchdogs the temperature ADC. Its outputs drive the controller's `start_button`, `temperature_sensor` and `water_level_sensor` inputs. All outputs reset to the safe-side values: no start, over-temperature, no water.

## Interface
- `DEBOUNCE_CYCLES`, 16: number of consecutive synchronised cycles a new button level must hold before it is accepted; legal range ≥ 2.
- `WATER_ON_TH`, 8'd40: `level_raw` at or above this value sets water present.
- `WATER_OFF_TH`, 8'd30: `level_raw` below this value clears water present; must be < `WATER_ON_TH`.
- `TEMP_TIMEOUT`, 1000: number of clocks without `temp_valid` before a fault is raised; legal range ≥ 2.
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start_raw` in 1: raw push-button, asynchronous to `clk`.
- `temp_raw` in 8: temperature ADC sample; synchronous to `clk`.
- `temp_valid` in 1: one-cycle strobe qualifying `temp_raw`.
- `level_raw` in 8: water-level ADC sample; synchronous to `clk`.
- `level_valid` in 1: one-cycle strobe qualifying `level_raw`.
- `start_button` out 1: debounced button level.
- `temperature_sensor` out 8: 4-sample averaged temperature, or 8'd255 when not valid.
- `water_level_sensor` out 1: hysteresis-filtered water present.
- `data_ready` out 1: high once the averaging window is full and no fault is active.
- `sensor_fault` out 1: temperature ADC watchdog expired.

## Operation
- **Reset values:** `start_button`=0, `temperature_sensor`=8'd255, `water_level_sensor`=0, `data_ready`=0, `sensor_fault`=0. The window, sum, fill count, debounce counter and watchdog counter all clear.
- **Button:**
  - `start_raw` passes through a 2-flop synchroniser (reset 0).
  - While the synchronised value equals `start_button`, the counter holds at 0.
  - While it differs, the counter increments each cycle. On the cycle the counter reaches `DEBOUNCE_CYCLES-1`, `start_button` takes the new level and the counter clears.
  - Any return to equality before that point clears the counter.
- **Temperature averaging:**
  - A 4-entry shift window holds samples, with a 10-bit running sum updated as sum + new − oldest. No overflow is possible (max 1020).
  - Fill count runs 0..4 and saturates at 4.
  - While fill < 4 after an accepted sample, `temperature_sensor` stays 8'd255 and `data_ready` stays 0.
  - Once fill = 4, `temperature_sensor` = sum[9:2] (truncating) and `data_ready` = 1.
- **Water hysteresis:** evaluated only on `level_valid`.
  - If the output is 0 and `level_raw` ≥ ON, the output becomes 1.
  - If the output is 1 and `level_raw` < OFF, the output becomes 0.
  - Otherwise the output holds.
  - Between strobes the output holds.
- **Watchdog:**
  - The counter clears on every `temp_valid` and otherwise increments, saturating.
  - When it reaches `TEMP_TIMEOUT`, `sensor_fault` is set. In the same cycle the window, sum and fill clear, `temperature_sensor` is forced to 8'd255, and `data_ready` goes to 0.
  - `sensor_fault` clears on the next `temp_valid`. That sample is the first entry of a fresh window (fill = 1).
- **Simultaneous events:**
  - `temp_valid` arriving on the same cycle the counter would reach timeout takes priority: no fault is raised.
  - `level_valid` and `temp_valid` are independent and may coincide.
- **Reset mid-operation:** any assertion of `rst` returns every output to its reset value immediately, regardless of clock.

## Timing
- **Button latency:** from an edge of `start_raw` to the change on `start_button` is 2 cycles (synchroniser) + `DEBOUNCE_CYCLES` cycles, provided the input holds steady.
- **Temperature latency:** a `temp_valid` at cycle N makes `temperature_sensor` reflect that sample at N+1. `data_ready` rises at N+1 of the 4th accepted sample.
- **Water latency:** a `level_valid` at cycle N updates `water_level_sensor` at N+1.
- **Fault timing:** `sensor_fault` rises on the cycle following the `TEMP_TIMEOUT`-th consecutive cycle without a strobe. It falls at N+1 of the next `temp_valid`.
- **Registering:** all outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset:** hold `rst`=0 mid-stream for 3 cycles → `temperature_sensor`=255, `water_level_sensor`=0, `start_button`=0, `data_ready`=0, `sensor_fault`=0 during and after reset.
- **Averaging:** `temp_valid` with samples 100, 102, 104, 106 → output stays 255 for the first three, then 103 with `data_ready`=1. A following sample 110 → output 105.
- **Hysteresis:** `level_raw` sequence 35, 40, 31, 29, 35 (each strobed) → `water_level_sensor` goes 0, 1, 1, 0, 0.
- **Debounce:** `start_raw` toggles high for 10 cycles then low (`DEBOUNCE_CYCLES`=16) → `start_button` stays 0. Holding high for 20 cycles → `start_button` rises exactly 18 cycles after the raw edge.
- **Watchdog:** with `TEMP_TIMEOUT`=8, stop `temp_valid` after a full window → `sensor_fault`=1, output 255, `data_ready`=0. One sample of 50 → fault clears and fill = 1. Four samples → `data_ready`=1.
- **Simultaneous events:** `temp_valid` on the exact timeout cycle → no fault; `temp_valid` and `level_valid` together → both outputs update at N+1.

Source files
------------

// File: rtl/kettle_sensor_frontend_if.sv
// Signal bundle between the raw kettle sensors and the conditioned controller inputs.
// The sensor side drives the raw samples; the frontend drives the conditioned outputs.
interface kettle_sensor_frontend_if;
    logic       start_raw;
    logic [7:0] temp_raw;
    logic       temp_valid;
    logic [7:0] level_raw;
    logic       level_valid;
    logic       start_button;
    logic [7:0] temperature_sensor;
    logic       water_level_sensor;
    logic       data_ready;
    logic       sensor_fault;

    modport master (
        output start_raw, temp_raw, temp_valid, level_raw, level_valid,
        input  start_button, temperature_sensor, water_level_sensor, data_ready, sensor_fault
    );

    modport slave (
        input  start_raw, temp_raw, temp_valid, level_raw, level_valid,
        output start_button, temperature_sensor, water_level_sensor, data_ready, sensor_fault
    );
endinterface

// File: rtl/kettle_sensor_frontend.sv
// Kettle sensor conditioning: button sync/debounce, 4-sample temperature average,
// water-level hysteresis and a temperature-ADC watchdog. All outputs registered.
module kettle_sensor_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [7:0]  WATER_ON_TH     = 8'd40,
    parameter logic [7:0]  WATER_OFF_TH    = 8'd30,
    parameter int unsigned TEMP_TIMEOUT    = 1000
) (
    input logic                     clk,
    input logic                     rst,
    kettle_sensor_frontend_if.slave bus
);
    localparam int unsigned       DEB_W        = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned       WD_W         = $clog2(TEMP_TIMEOUT + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT     = WD_W'(TEMP_TIMEOUT);
    localparam logic [7:0]        TEMP_INVALID = 8'd255;
    localparam logic [2:0]        FILL_FULL    = 3'd4;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             btn_q, btn_d;
    logic             water_q, water_d;
    logic [7:0]       win_q [4];
    logic [7:0]       win_d [4];
    logic [9:0]       sum_q, sum_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       temp_q, temp_d;
    logic             ready_q, ready_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             fault_q, fault_d;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        sync1_d   = bus.start_raw;
        sync2_d   = sync1_q;
        btn_d     = btn_q;
        deb_cnt_d = '0;
        if (sync2_q != btn_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        water_d = water_q;
        if (bus.level_valid) begin
            if (!water_q && (bus.level_raw >= WATER_ON_TH)) begin
                water_d = 1'b1;
            end else if (water_q && (bus.level_raw < WATER_OFF_TH)) begin
                water_d = 1'b0;
            end
        end

        win_d   = win_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        temp_d  = temp_q;
        ready_d = ready_q;
        wd_d    = wd_q;
        fault_d = fault_q;
        if (bus.temp_valid) begin
            wd_d     = '0;
            fault_d  = 1'b0;
            win_d[0] = bus.temp_raw;
            win_d[1] = win_q[0];
            win_d[2] = win_q[1];
            win_d[3] = win_q[2];
            // Unfilled slots are zero, so subtracting the oldest slot is safe while filling.
            sum_d    = sum_q + {2'b00, bus.temp_raw} - {2'b00, win_q[3]};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 3'd1;
            end
            if (fill_d == FILL_FULL) begin
                temp_d  = sum_d[9:2];
                ready_d = 1'b1;
            end else begin
                temp_d  = TEMP_INVALID;
                ready_d = 1'b0;
            end
        end else if (wd_q != WD_LIMIT) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_LIMIT) begin
                fault_d = 1'b1;
                win_d   = '{default: 8'd0};
                sum_d   = '0;
                fill_d  = '0;
                temp_d  = TEMP_INVALID;
                ready_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            btn_q     <= 1'b0;
            water_q   <= 1'b0;
            // NOTE: the sample window is reset because the running sum relies on empty slots being zero.
            win_q     <= '{default: 8'd0};
            sum_q     <= '0;
            fill_q    <= '0;
            temp_q    <= TEMP_INVALID;
            ready_q   <= 1'b0;
            wd_q      <= '0;
            fault_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            btn_q     <= btn_d;
            water_q   <= water_d;
            win_q     <= win_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            temp_q    <= temp_d;
            ready_q   <= ready_d;
            wd_q      <= wd_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.start_button       = btn_q;
    assign bus.temperature_sensor = temp_q;
    assign bus.water_level_sensor = water_q;
    assign bus.data_ready         = ready_q;
    assign bus.sensor_fault       = fault_q;
endmodule

// File: tb/tb_kettle_sensor_frontend.sv
// Self-checking bench: directed cases with hand-computed values, then randomized traffic
// compared every cycle against a queue-based behavioural model of the frontend.
module tb_kettle_sensor_frontend;
    localparam int DEB = 16;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kettle_sensor_frontend_if bus ();

    kettle_sensor_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .WATER_ON_TH    (8'd40),
        .WATER_OFF_TH   (8'd30),
        .TEMP_TIMEOUT   (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " start_button"}, {31'd0, bus.start_button}, 32'd0);
        check({tag, " temperature"}, {24'd0, bus.temperature_sensor}, 32'd255);
        check({tag, " water"}, {31'd0, bus.water_level_sensor}, 32'd0);
        check({tag, " data_ready"}, {31'd0, bus.data_ready}, 32'd0);
        check({tag, " sensor_fault"}, {31'd0, bus.sensor_fault}, 32'd0);
    endtask

    // Behavioural model: sample list, idle-cycle count, delayed button and a run length.
    bit m_btn   = 1'b0;
    int m_temp  = 255;
    bit m_water = 1'b0;
    bit m_ready = 1'b0;
    bit m_fault = 1'b0;
    bit m_s1 = 1'b0, m_s2 = 1'b0, m_old;
    int m_run = 0, m_idle = 0, m_sum;
    int m_win[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_btn = 1'b0; m_temp = 255; m_water = 1'b0; m_ready = 1'b0; m_fault = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_idle = 0;
            m_win.delete();
        end else begin
            m_old = m_s2;
            m_s2  = m_s1;
            m_s1  = bus.start_raw;
            if (m_old != m_btn) begin
                m_run++;
                if (m_run == DEB) begin
                    m_btn = m_old;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end

            if (bus.level_valid) begin
                if (!m_water && bus.level_raw >= 40) m_water = 1'b1;
                else if (m_water && bus.level_raw < 30) m_water = 1'b0;
            end

            if (bus.temp_valid) begin
                m_idle  = 0;
                m_fault = 1'b0;
                m_win.push_back(int'(bus.temp_raw));
                if (m_win.size() > 4) void'(m_win.pop_front());
                if (m_win.size() == 4) begin
                    m_sum = 0;
                    foreach (m_win[i]) m_sum += m_win[i];
                    m_temp  = m_sum / 4;
                    m_ready = 1'b1;
                end else begin
                    m_temp  = 255;
                    m_ready = 1'b0;
                end
            end else if (m_idle < TO) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_fault = 1'b1;
                    m_win.delete();
                    m_temp  = 255;
                    m_ready = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model start_button", {31'd0, bus.start_button}, {31'd0, m_btn});
            check("model temperature", {24'd0, bus.temperature_sensor}, 32'(m_temp));
            check("model water", {31'd0, bus.water_level_sensor}, {31'd0, m_water});
            check("model data_ready", {31'd0, bus.data_ready}, {31'd0, m_ready});
            check("model sensor_fault", {31'd0, bus.sensor_fault}, {31'd0, m_fault});
        end
    end

    initial begin
        int avg_in[5]  = '{100, 102, 104, 106, 110};
        int avg_exp[5] = '{255, 255, 255, 103, 105};
        int lvl_in[5]  = '{35, 40, 31, 29, 35};
        int lvl_exp[5] = '{0, 1, 1, 0, 0};
        int rate = 5;

        bus.start_raw   = 1'b0;
        bus.temp_raw    = 8'd0;
        bus.temp_valid  = 1'b0;
        bus.level_raw   = 8'd0;
        bus.level_valid = 1'b0;

        repeat (3) tick();
        check_reset_values("in reset");
        cmp_en = 1'b1;
        rst = 1'b1;

        // Averaging: three invalid outputs, then the truncated mean of the window.
        for (int i = 0; i < 5; i++) begin
            bus.temp_valid = 1'b1;
            bus.temp_raw   = 8'(avg_in[i]);
            tick();
            check("avg temperature", {24'd0, bus.temperature_sensor}, 32'(avg_exp[i]));
            check("avg data_ready", {31'd0, bus.data_ready}, (i >= 3) ? 32'd1 : 32'd0);
        end
        bus.temp_valid = 1'b0;

        // Hysteresis.
        for (int i = 0; i < 5; i++) begin
            bus.level_valid = 1'b1;
            bus.level_raw   = 8'(lvl_in[i]);
            tick();
            check("hyst water", {31'd0, bus.water_level_sensor}, 32'(lvl_exp[i]));
        end
        bus.level_valid = 1'b0;

        // Debounce: short glitch rejected, then a steady press accepted after exactly 18 cycles.
        bus.start_raw = 1'b1;
        repeat (10) tick();
        bus.start_raw = 1'b0;
        repeat (30) tick();
        check("glitch start_button", {31'd0, bus.start_button}, 32'd0);
        bus.start_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 17) check("debounce k17", {31'd0, bus.start_button}, 32'd0);
            if (k == 18) check("debounce k18", {31'd0, bus.start_button}, 32'd1);
        end
        bus.start_raw = 1'b0;

        // Watchdog: fill window, go silent, recover with a fresh window.
        for (int i = 0; i < 4; i++) begin
            bus.temp_valid = 1'b1;
            bus.temp_raw   = 8'(20 + 20 * i);
            tick();
        end
        bus.temp_valid = 1'b0;
        check("wd full ready", {31'd0, bus.data_ready}, 32'd1);
        check("wd full temp", {24'd0, bus.temperature_sensor}, 32'd50);
        repeat (TO - 1) tick();
        check("wd before timeout", {31'd0, bus.sensor_fault}, 32'd0);
        tick();
        check("wd fault", {31'd0, bus.sensor_fault}, 32'd1);
        check("wd fault temp", {24'd0, bus.temperature_sensor}, 32'd255);
        check("wd fault ready", {31'd0, bus.data_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.temp_valid = 1'b1;
            bus.temp_raw   = 8'(50 + 10 * i);
            tick();
            if (i == 0) begin
                check("recover fault", {31'd0, bus.sensor_fault}, 32'd0);
                check("recover temp", {24'd0, bus.temperature_sensor}, 32'd255);
                check("recover ready", {31'd0, bus.data_ready}, 32'd0);
            end
        end
        bus.temp_valid = 1'b0;
        check("refill ready", {31'd0, bus.data_ready}, 32'd1);
        check("refill temp", {24'd0, bus.temperature_sensor}, 32'd65);

        // Strobe on the timeout cycle wins; level strobe in the same cycle.
        repeat (TO - 1) tick();
        bus.temp_valid  = 1'b1;
        bus.temp_raw    = 8'd90;
        bus.level_valid = 1'b1;
        bus.level_raw   = 8'd50;
        tick();
        bus.temp_valid  = 1'b0;
        bus.level_valid = 1'b0;
        check("simul fault", {31'd0, bus.sensor_fault}, 32'd0);
        check("simul temp", {24'd0, bus.temperature_sensor}, 32'd75);
        check("simul water", {31'd0, bus.water_level_sensor}, 32'd1);

        // Randomized traffic with varying temperature strobe density and a mid-run reset.
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = int'($urandom_range(0, 9));
            bus.temp_valid  = (int'($urandom_range(0, 9)) < rate);
            bus.temp_raw    = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            bus.level_valid = ($urandom_range(0, 2) == 0);
            bus.level_raw   = 8'($urandom_range(20, 50));
            if ($urandom_range(0, 24) == 0) bus.start_raw = ~bus.start_raw;
            if (c == 1500) begin
                rst = 1'b0;
                #1;
                check_reset_values("async reset");
                repeat (3) tick();
                check_reset_values("held reset");
                rst = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
